// File: rtl/instr_fetch_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | instr_fetch_pkg: shared types and constants for the fetch stage     |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package instr_fetch_pkg;

    typedef logic [31:0] instr_t;

    localparam logic [31:0] FETCH_PC_INC = 32'd4;

    typedef enum logic [0:0] {
        FETCH_RUN   = 1'b0,
        FETCH_DRAIN = 1'b1
    } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/instr_fetch_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | instr_fetch_fifo: synchronous FIFO with flush, power-of-2 depth     |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module instr_fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_wdata,
    input  logic                   i_pop,
    input  logic                   i_flush,
    output logic [WIDTH-1:0]       o_rdata,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_full,
    output logic                   o_empty
);
    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    // Flush dominates any push/pop issued in the same cycle.
    assign w_push = i_push && !i_flush;
    assign w_pop  = i_pop && !i_flush;

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_wdata;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(w_push && o_full));
            assert (!(w_pop && o_empty));
        end
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_full  = (r_count == FULL_CNT);
    assign o_empty = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | instr_fetch: sequential PC fetch, buffering and redirect flushing   |
// | Option macro: FETCH_MISALIGN_EN (sticky FAULT on misaligned target) |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        o_mem_req,
    output logic [31:0] o_mem_addr,
    input  logic        i_mem_gnt,
    input  logic        i_mem_rvalid,
    input  logic [31:0] i_mem_rdata,
    output instr_t      o_instr,
    output logic [31:0] o_instr_pc,
    output logic        o_instr_valid,
    input  logic        i_instr_ready,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_fault
);
    localparam int            CW         = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] MAX_CREDIT = FIFO_DEPTH[CW-1:0];

    fetch_state_t  r_state;
    fetch_state_t  w_state_nxt;
    logic [31:0]   r_pc;
    logic [CW-1:0] r_inflight;
    logic [CW-1:0] r_drop;
    logic [CW-1:0] w_inflight_nxt;
    logic [CW-1:0] w_drop_nxt;
    logic [CW-1:0] w_ibuf_count;
    logic [CW-1:0] w_pcq_count;
    logic [63:0]   w_ibuf_rdata;
    logic [31:0]   w_pcq_rdata;
    logic [31:0]   w_redirect_pc;
    logic          w_ibuf_empty;
    logic          w_ibuf_full_unused;
    logic          w_pcq_full_unused;
    logic          w_pcq_empty_unused;
    logic          w_fault;
    logic          w_req;
    logic          w_fire;
    logic          w_accept;
    logic          w_pop;

`ifdef FETCH_MISALIGN_EN
    logic r_fault;

    always_ff @(posedge clk) begin
        if (rst)             r_fault <= 1'b0;
        else if (i_redirect) r_fault <= |i_redirect_pc[1:0];
    end

    assign w_fault = r_fault;
`else
    logic w_misalign_unused;

    assign w_misalign_unused = ^i_redirect_pc[1:0];
    assign w_fault           = 1'b0;
`endif

    assign w_redirect_pc = {i_redirect_pc[31:2], 2'b00};

    always_comb begin
        w_req          = 1'b0;
        w_fire         = 1'b0;
        w_accept       = 1'b0;
        w_pop          = 1'b0;
        w_drop_nxt     = r_drop;
        w_inflight_nxt = r_inflight;
        w_state_nxt    = r_state;

        // Buffered plus outstanding words never exceed the buffer size.
        w_req    = !rst && (r_state == FETCH_RUN) && !w_fault
                   && ((w_ibuf_count + r_inflight) < MAX_CREDIT);
        w_fire   = w_req && i_mem_gnt;
        w_accept = i_mem_rvalid && (r_drop == '0) && !i_redirect;
        w_pop    = o_instr_valid && i_instr_ready && !i_redirect;

        if (i_redirect) begin
            // Every read still owed by memory becomes a discard, including this cycle's grant.
            w_drop_nxt     = r_drop + r_inflight + {{(CW-1){1'b0}}, w_fire}
                             - {{(CW-1){1'b0}}, i_mem_rvalid};
            w_inflight_nxt = '0;
        end else begin
            w_drop_nxt     = r_drop - {{(CW-1){1'b0}}, (i_mem_rvalid && (r_drop != '0))};
            w_inflight_nxt = r_inflight + {{(CW-1){1'b0}}, w_fire}
                             - {{(CW-1){1'b0}}, w_accept};
        end

        w_state_nxt = (w_drop_nxt != '0) ? FETCH_DRAIN : FETCH_RUN;
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= FETCH_RUN;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc       <= RESET_PC;
            r_inflight <= '0;
            r_drop     <= '0;
        end else begin
            r_inflight <= w_inflight_nxt;
            r_drop     <= w_drop_nxt;
            if (i_redirect)  r_pc <= w_redirect_pc;
            else if (w_fire) r_pc <= r_pc + FETCH_PC_INC;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(i_mem_rvalid && (r_drop == '0) && (r_inflight == '0)));
            assert ((w_ibuf_count + r_inflight) <= MAX_CREDIT);
            assert (w_pcq_count == r_inflight);
        end
    end

    instr_fetch_fifo #(
        .WIDTH (64),
        .DEPTH (FIFO_DEPTH)
    ) u_ibuf (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_accept),
        .i_wdata ({i_mem_rdata, w_pcq_rdata}),
        .i_pop   (w_pop),
        .i_flush (i_redirect),
        .o_rdata (w_ibuf_rdata),
        .o_count (w_ibuf_count),
        .o_full  (w_ibuf_full_unused),
        .o_empty (w_ibuf_empty)
    );

    // PCs of granted reads, consumed in return order to tag each word.
    instr_fetch_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_pcq (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_fire),
        .i_wdata (r_pc),
        .i_pop   (w_accept),
        .i_flush (i_redirect),
        .o_rdata (w_pcq_rdata),
        .o_count (w_pcq_count),
        .o_full  (w_pcq_full_unused),
        .o_empty (w_pcq_empty_unused)
    );

    assign o_mem_req     = w_req;
    assign o_mem_addr    = r_pc;
    assign o_instr_valid = !w_ibuf_empty;
    assign {o_instr, o_instr_pc} = o_instr_valid ? w_ibuf_rdata : 64'd0;
    assign o_fault       = w_fault;

endmodule
`default_nettype wire
